// File: rtl/al_accel_pkg.sv
// Shared definitions for the accelerator controllers: window width and sequencer states.
package al_accel_pkg;

  // Window width in columns; equals the ireg lane count and the minimum legal image width.
  localparam int unsigned KW = 3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/al_accel_win_cnt.sv
// Column/row position counters for the ireg sequencer, with wrap and end-of-job flags.
module al_accel_win_cnt #(
  parameter int unsigned COL_W = 8,
  parameter int unsigned ROW_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inc,
  input  logic             clr,
  input  logic [COL_W-1:0] cfg_width,
  input  logic [ROW_W-1:0] cfg_rows,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             col_wrap,
  output logic             job_last
);

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;

  // Legal configs guarantee cfg_width >= 3 and cfg_rows >= 1, so the minus-one never underflows.
  assign col_wrap = (r_col == (cfg_width - COL_W'(1)));
  assign job_last = col_wrap && (r_row == (cfg_rows - ROW_W'(1)));
  assign col      = r_col;
  assign row      = r_row;

  // Advance one column per accepted beat; wrap to the next row-band at the end of a row.
  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      r_col <= '0;
      r_row <= '0;
    end else if (inc) begin
      if (col_wrap) begin
        r_col <= '0;
        r_row <= r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/al_accel_ireg_ctrl.sv
// Input-register sequencer: paces the column stream into the 3-lane ireg and
// announces each complete 3-column window to the window/MAC stage.
module al_accel_ireg_ctrl
  import al_accel_pkg::*;
#(
  parameter int unsigned COL_W = 8,
  parameter int unsigned ROW_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  input  logic [COL_W-1:0] cfg_width,
  input  logic [ROW_W-1:0] cfg_rows,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ireg_enb,
  output logic             win_shift,
  output logic             win_valid,
  input  logic             win_ready,
  output logic [COL_W-1:0] win_col,
  output logic [ROW_W-1:0] win_row,
  output logic             win_last
);

  state_e           r_state;
  logic [COL_W-1:0] r_cfg_width;
  logic [ROW_W-1:0] r_cfg_rows;
  logic             r_fed_all;  // last column of the job already accepted
  logic             r_done;
  logic             r_cfg_err;
  logic             r_win_shift;
  logic             r_win_valid;
  logic [COL_W-1:0] r_win_col;
  logic [ROW_W-1:0] r_win_row;
  logic             r_win_last;

  logic             w_in_ready;
  logic             w_ireg_enb;
  logic             w_hs;
  logic             w_cfg_ok;
  logic             w_start_ok;
  logic [COL_W-1:0] w_col;
  logic [ROW_W-1:0] w_row;
  logic             w_col_wrap;
  logic             w_job_last;

  // Abort masks the accept so the ireg is never loaded in the cancel cycle.
  assign w_in_ready = (r_state == RUN) && !r_fed_all && !abort && (!r_win_valid || win_ready);
  assign w_ireg_enb = in_valid && w_in_ready;
  assign w_hs       = r_win_valid && win_ready;
  assign w_cfg_ok   = (cfg_width >= COL_W'(KW)) && (cfg_rows != '0);
  assign w_start_ok = (r_state == IDLE) && start && w_cfg_ok;

  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign cfg_err   = r_cfg_err;
  assign in_ready  = w_in_ready;
  assign ireg_enb  = w_ireg_enb;
  assign win_shift = r_win_shift;
  assign win_valid = r_win_valid;
  assign win_col   = r_win_col;
  assign win_row   = r_win_row;
  assign win_last  = r_win_last;

  al_accel_win_cnt #(
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_win_cnt (
    .clk       (clk),
    .resetn    (resetn),
    .inc       (w_ireg_enb),
    .clr       (w_start_ok),
    .cfg_width (r_cfg_width),
    .cfg_rows  (r_cfg_rows),
    .col       (w_col),
    .row       (w_row),
    .col_wrap  (w_col_wrap),
    .job_last  (w_job_last)
  );

  // Job FSM plus all registered handshake/window outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_cfg_width <= '0;
      r_cfg_rows  <= '0;
      r_fed_all   <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_win_shift <= 1'b0;
      r_win_valid <= 1'b0;
      r_win_col   <= '0;
      r_win_row   <= '0;
      r_win_last  <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_win_shift <= w_ireg_enb;
      case (r_state)
        IDLE: begin
          // start beats a coincident abort here since abort has nothing to cancel.
          if (start) begin
            if (w_cfg_ok) begin
              r_cfg_width <= cfg_width;
              r_cfg_rows  <= cfg_rows;
              r_fed_all   <= 1'b0;
              r_state     <= RUN;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            r_state     <= IDLE;
            r_win_valid <= 1'b0;
            r_win_last  <= 1'b0;
            r_fed_all   <= 1'b0;
          end else begin
            if (w_hs) begin
              r_win_valid <= 1'b0;
              r_win_last  <= 1'b0;
              if (r_win_last) begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end
            end
            // An accept in the handshake cycle overrides the clear: back-to-back windows.
            if (w_ireg_enb) begin
              if (w_col >= COL_W'(KW - 1)) begin
                r_win_valid <= 1'b1;
                r_win_col   <= w_col - COL_W'(KW - 1);
                r_win_row   <= w_row;
                r_win_last  <= w_job_last;
              end
              if (w_job_last) begin
                r_fed_all <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          r_state   <= IDLE;
          r_fed_all <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Row-wrap flag is implied by job_last/col arithmetic; kept visible for debug probes.
  logic w_unused;
  assign w_unused = w_col_wrap;

endmodule

// File: tb/tb_al_accel_ireg_ctrl.sv
// Self-checking bench for al_accel_ireg_ctrl: table of job configs with randomized
// valid/ready traffic, checked against a window-list model, plus abort/reset sequences.
module tb_al_accel_ireg_ctrl;

  localparam int KW = 3;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic       abort;
  logic [7:0] cfg_width;
  logic [7:0] cfg_rows;
  logic       busy;
  logic       done;
  logic       cfg_err;
  logic       in_valid;
  logic       in_ready;
  logic       ireg_enb;
  logic       win_shift;
  logic       win_valid;
  logic       win_ready;
  logic [7:0] win_col;
  logic [7:0] win_row;
  logic       win_last;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int w;
    int r;
    int vpct;
    int rpct;
    bit exp_err;
    int exp_win;
    int exp_last_col;
    bit stall;
    bit restart;
  } vec_t;

  typedef struct {
    int col;
    int row;
    bit last;
  } win_t;

  vec_t vecs[$];
  win_t exp_q[$];

  al_accel_ireg_ctrl #(
    .COL_W (8),
    .ROW_W (8)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .abort     (abort),
    .cfg_width (cfg_width),
    .cfg_rows  (cfg_rows),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ireg_enb  (ireg_enb),
    .win_shift (win_shift),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_col   (win_col),
    .win_row   (win_row),
    .win_last  (win_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cfg_err"}, cfg_err, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_ireg_enb"}, ireg_enb, 0);
    chk({tag, "_win_shift"}, win_shift, 0);
    chk({tag, "_win_valid"}, win_valid, 0);
    chk({tag, "_win_col"}, win_col, 0);
    chk({tag, "_win_row"}, win_row, 0);
    chk({tag, "_win_last"}, win_last, 0);
  endtask

  // Expected window list: one window for every column at or past KW-1 in each row-band.
  task automatic build_model(input int w, input int r);
    exp_q.delete();
    for (int row = 0; row < r; row++) begin
      for (int c = KW - 1; c < w; c++) begin
        exp_q.push_back('{c - (KW - 1), row, (row == r - 1) && (c == w - 1)});
      end
    end
  endtask

  task automatic run_job(input vec_t v);
    int   acc;
    int   shf;
    int   hs;
    int   stall_cyc;
    int   last_hs;
    int   last_col;
    bit   done_seen;
    bit   exp_rdy;
    win_t e;
    acc = 0; shf = 0; hs = 0; stall_cyc = 0; last_hs = -10; last_col = -1; done_seen = 0;
    @(negedge clk);
    cfg_width = 8'(v.w);
    cfg_rows  = 8'(v.r);
    start     = 1'b1;
    in_valid  = 1'b0;
    win_ready = 1'b0;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    #1;
    chk("start_cfg_err", cfg_err, v.exp_err);
    chk("start_busy", busy, !v.exp_err);
    if (v.exp_err) begin
      chk("err_in_ready", in_ready, 0);
      chk("err_ireg_enb", ireg_enb, 0);
      @(negedge clk);
      #1;
      chk("err_pulse_len", cfg_err, 0);
      chk("err_busy_after", busy, 0);
      in_valid = 1'b0;
      return;
    end
    build_model(v.w, v.r);
    for (int cyc = 0; cyc < 5000 && !done_seen; cyc++) begin
      in_valid  = ($urandom_range(0, 99) < v.vpct);
      win_ready = ($urandom_range(0, 99) < v.rpct);
      if (v.stall && hs == 0 && stall_cyc < 3) win_ready = 1'b0;
      if (v.restart && cyc == 4) begin
        start     = 1'b1;
        cfg_width = 8'd2;
      end else begin
        start = 1'b0;
      end
      #1;
      exp_rdy = (acc < v.w * v.r) && (!win_valid || win_ready);
      chk("in_ready", in_ready, exp_rdy);
      chk("ireg_enb", ireg_enb, in_valid && exp_rdy);
      if (v.restart && cyc == 5) begin
        chk("busy_start_no_err", cfg_err, 0);
        chk("busy_start_busy", busy, 1);
      end
      if (v.stall && win_valid && hs == 0 && stall_cyc < 3) begin
        chk("stall_in_ready", in_ready, 0);
        chk("stall_ireg_enb", ireg_enb, 0);
        chk("stall_win_col", win_col, 0);
        stall_cyc++;
      end
      if (win_shift) shf++;
      if (ireg_enb) acc++;
      if (done) begin
        done_seen = 1'b1;
        chk("done_latency", cyc - last_hs, 1);
      end
      if (win_valid && win_ready) begin
        if (exp_q.size() == 0) begin
          chk("win_extra", hs + 1, v.exp_win);
        end else begin
          e = exp_q.pop_front();
          chk("win_col", win_col, e.col);
          chk("win_row", win_row, e.row);
          chk("win_last", win_last, e.last);
        end
        last_col = win_col;
        last_hs  = cyc;
        hs++;
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    win_ready = 1'b0;
    start     = 1'b0;
    #1;
    chk("done_seen", done_seen, 1);
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
    chk("accept_count", acc, v.w * v.r);
    chk("shift_count", shf, v.w * v.r);
    chk("window_count", hs, v.exp_win);
    chk("last_win_col", last_col, v.exp_last_col);
    chk("model_drained", exp_q.size(), 0);
    if (v.stall) chk("stall_cycles", stall_cyc, 3);
  endtask

  task automatic abort_seq();
    int acc;
    acc = 0;
    @(negedge clk);
    cfg_width = 8'd6;
    cfg_rows  = 8'd3;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    in_valid  = 1'b1;
    win_ready = 1'b1;
    for (int i = 0; i < 100 && acc < 8; i++) begin
      #1;
      if (ireg_enb) acc++;
      @(negedge clk);
    end
    chk("abort_pre_accepts", acc, 8);
    abort = 1'b1;
    #1;
    chk("abort_ireg_enb", ireg_enb, 0);
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_win_valid", win_valid, 0);
    chk("abort_win_last", win_last, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_done", done, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("abort_no_done", done, 0);
    end
    in_valid  = 1'b0;
    win_ready = 1'b0;
  endtask

  task automatic reset_seq();
    @(negedge clk);
    cfg_width = 8'd5;
    cfg_rows  = 8'd2;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    in_valid  = 1'b1;
    win_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("pre_reset_busy", busy, 1);
    resetn   = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk_all_zero("midreset");
    resetn    = 1'b1;
    win_ready = 1'b0;
  endtask

  initial begin
    vec_t v;
    int   w;
    int   r;
    resetn    = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    cfg_width = '0;
    cfg_rows  = '0;
    in_valid  = 1'b0;
    win_ready = 1'b0;
    vecs.push_back('{5, 2, 100, 100, 1'b0, 6, 2, 1'b0, 1'b0});
    vecs.push_back('{4, 1, 100, 100, 1'b0, 2, 1, 1'b1, 1'b0});
    vecs.push_back('{2, 1, 100, 100, 1'b1, 0, 0, 1'b0, 1'b0});
    vecs.push_back('{5, 0, 100, 100, 1'b1, 0, 0, 1'b0, 1'b0});
    vecs.push_back('{6, 2, 100, 100, 1'b0, 8, 3, 1'b0, 1'b1});
    vecs.push_back('{7, 3, 60, 50, 1'b0, 15, 4, 1'b0, 1'b0});
    vecs.push_back('{3, 2, 80, 70, 1'b0, 2, 0, 1'b0, 1'b0});
    vecs.push_back('{255, 1, 100, 100, 1'b0, 253, 252, 1'b0, 1'b0});

    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    resetn = 1'b1;

    foreach (vecs[i]) run_job(vecs[i]);

    abort_seq();
    run_job('{3, 1, 100, 100, 1'b0, 1, 0, 1'b0, 1'b0});

    reset_seq();
    run_job('{6, 2, 100, 100, 1'b0, 8, 3, 1'b0, 1'b1});

    for (int k = 0; k < 6; k++) begin
      w = $urandom_range(3, 10);
      r = $urandom_range(1, 3);
      v = '{w, r, $urandom_range(40, 100), $urandom_range(40, 100), 1'b0,
            (w - 2) * r, w - 3, 1'b0, 1'b0};
      run_job(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
